keypad_event_decoder: RTL

- Consumer end of the keypad scanner interface. It takes the scanner's {row one-hot, column one-hot} key code and its strobe.
- Each valid press is decoded to a key index and an ASCII character. Held-key repeats are suppressed.
- Decoded events are buffered in a small FIFO, which the downstream logic (calculator/game core) drains with a valid/ready handshake.

---
 rtl/keypad_event_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/keypad_event_decoder.sv
// Keypad scanner consumer: classifies strobed key codes, suppresses held-key repeats,
// and queues decoded {index, ascii} events in a show-ahead FIFO drained by valid/ready.
//
// state        | meaning
// IDLE         | no key held; next valid strobe is a new press
// HELD         | held_key is down; repeats of it are ignored
// RELEASE_WAIT | cur_key went to 0; waiting for RELEASE_CYCLES zero cycles in a row
module keypad_event_decoder #(
  parameter int DEPTH          = 4,
  parameter int RELEASE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cur_key,
  input  logic       strobe,
  input  logic       key_ready,
  input  logic       clear_ovf,
  output logic       key_valid,
  output logic [3:0] key_index,
  output logic [7:0] key_ascii,
  output logic       overflow,
  output logic [7:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;
  localparam logic [7:0] REL_LAST = 8'(RELEASE_CYCLES - 1);

  logic [1:0]  state, state_nx;
  logic [7:0]  held_key, held_nx;
  logic [7:0]  rel_cnt, rel_cnt_nx;
  logic        push;

  logic [3:0]  row_bits, col_bits;
  logic [1:0]  row, col;
  logic        row_ok, col_ok, code_valid, code_zero, code_bad, new_key;
  logic [11:0] new_event;

  logic [11:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [11:0] last_event, head_event;
  logic        empty, full, pop, do_push, drop;

  function automatic logic [7:0] ascii_of(input logic [3:0] idx);
    case (idx)
      4'd0:  ascii_of = 8'h31;
      4'd1:  ascii_of = 8'h32;
      4'd2:  ascii_of = 8'h33;
      4'd3:  ascii_of = 8'h41;
      4'd4:  ascii_of = 8'h34;
      4'd5:  ascii_of = 8'h35;
      4'd6:  ascii_of = 8'h36;
      4'd7:  ascii_of = 8'h42;
      4'd8:  ascii_of = 8'h37;
      4'd9:  ascii_of = 8'h38;
      4'd10: ascii_of = 8'h39;
      4'd11: ascii_of = 8'h43;
      4'd12: ascii_of = 8'h2A;
      4'd13: ascii_of = 8'h30;
      4'd14: ascii_of = 8'h23;
      default: ascii_of = 8'h44;
    endcase
  endfunction

  // Bit 7 is row0 and bit 3 is col0, so the MSB of each nibble maps to index 0.
  assign row_bits   = cur_key[7:4];
  assign col_bits   = cur_key[3:0];
  assign row        = row_bits[3] ? 2'd0 : row_bits[2] ? 2'd1 : row_bits[1] ? 2'd2 : 2'd3;
  assign col        = col_bits[3] ? 2'd0 : col_bits[2] ? 2'd1 : col_bits[1] ? 2'd2 : 2'd3;
  assign row_ok     = (row_bits != 4'd0) && ((row_bits & (row_bits - 4'd1)) == 4'd0);
  assign col_ok     = (col_bits != 4'd0) && ((col_bits & (col_bits - 4'd1)) == 4'd0);
  assign code_valid = row_ok && col_ok;
  assign code_zero  = (cur_key == 8'd0);
  assign code_bad   = strobe && !code_valid && !code_zero;
  assign new_key    = strobe && code_valid && (cur_key != held_key);
  assign new_event  = {row, col, ascii_of({row, col})};

  // rel_cnt counts consecutive zero cycles, including the one that left HELD.
  always_comb begin
    state_nx   = state;
    held_nx    = held_key;
    rel_cnt_nx = rel_cnt;
    push       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (strobe && code_valid) begin
          push     = 1'b1;
          held_nx  = cur_key;
          state_nx = ST_HELD;
        end
      end
      ST_HELD: begin
        if (new_key) begin
          push    = 1'b1;
          held_nx = cur_key;
        end else if (code_zero) begin
          if (RELEASE_CYCLES == 1) begin
            held_nx  = 8'd0;
            state_nx = ST_IDLE;
          end else begin
            rel_cnt_nx = 8'd1;
            state_nx   = ST_REL;
          end
        end
      end
      ST_REL: begin
        if (new_key) begin
          push     = 1'b1;
          held_nx  = cur_key;
          state_nx = ST_HELD;
        end else if (cur_key == held_key) begin
          state_nx = ST_HELD;
        end else if (code_zero) begin
          if (rel_cnt == REL_LAST) begin
            held_nx    = 8'd0;
            rel_cnt_nx = 8'd0;
            state_nx   = ST_IDLE;
          end else begin
            rel_cnt_nx = rel_cnt + 8'd1;
          end
        end else begin
          rel_cnt_nx = 8'd0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = key_valid && key_ready;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      held_key   <= 8'd0;
      rel_cnt    <= 8'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_event <= 12'd0;
      overflow   <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      state    <= state_nx;
      held_key <= held_nx;
      rel_cnt  <= rel_cnt_nx;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        last_event <= head_event;
      end
      if (drop) overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
      if (code_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= new_event;
  end

  assign key_valid  = !empty;
  assign head_event = mem[rd_ptr[AW-1:0]];
  // When empty the outputs keep showing the most recently popped event.
  assign {key_index, key_ascii} = key_valid ? head_event : last_event;

endmodule
